// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler
// Shares one UART transmitter and its baud-rate generator among NREQ
// requesters. A round-robin arbiter picks an owner. The block reprograms the
// generator rate (holding it in reset while the new rate settles), pulses
// tx_start, waits for tx_done (or a timeout), then acks the owner.
//
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   req             per-requester request, held until ack
//   req_data        packed bytes, requester i at [8i+7:8i]
//   req_rate        packed rate codes, requester i at [2i+1:2i]
//   grant           one-hot owner of the current transaction
//   ack             one-cycle completion pulse to the owner
//   err             pulses with ack when the transaction timed out
//   tx_start        one-cycle start pulse to the transmitter
//   tx_data         byte to the transmitter
//   tx_done         transmitter frame-complete pulse
//   baud_sel        rate code to the baud generator
//   baud_rst_n      active-low reset to the baud generator
module uart_tx_scheduler #(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 300000,
  parameter int TO_W          = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_rate,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [1:0]        baud_sel,
  output logic              baud_rst_n
);

  localparam int          PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          SW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      baud_sel_q, baud_sel_d;
  logic            baud_rst_n_q, baud_rst_n_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [1:0]      rate_q, rate_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Round-robin pick: first set request at or above rr_ptr, wrapping.
  logic          found;
  logic [PW-1:0] pick;

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      idx = {{(32-PW){1'b0}}, rr_ptr_q} + i;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Pulse outputs (tx_start, ack, err) are registered on entry to the state
  // they belong to, so they are high during that state's single cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    err_d        = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    baud_sel_d   = baud_sel_q;
    baud_rst_n_d = baud_rst_n_q;
    cfg_valid_d  = cfg_valid_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    rate_d       = rate_q;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          tx_data_d     = req_data[{pick, 3'b000} +: 8];
          rate_d        = req_rate[{pick, 1'b0} +: 2];
          state_d       = ST_CFG;
        end
      end
      ST_CFG: begin
        if (!cfg_valid_q || (rate_q != baud_sel_q)) begin
          baud_sel_d   = rate_q;
          baud_rst_n_d = 1'b0;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else begin
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          baud_rst_n_d = 1'b1;
          cfg_valid_d  = 1'b1;
          tx_start_d   = 1'b1;
          state_d      = ST_START;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done takes priority over a timeout in the same cycle.
        if (tx_done) begin
          ack_d[owner_q] = 1'b1;
          state_d        = ST_DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          ack_d[owner_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        grant_d  = '0;
        rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      baud_sel_q   <= '0;
      baud_rst_n_q <= 1'b0;
      cfg_valid_q  <= 1'b0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      rate_q       <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      baud_sel_q   <= baud_sel_d;
      baud_rst_n_q <= baud_rst_n_d;
      cfg_valid_q  <= cfg_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      rate_q       <= rate_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign baud_sel   = baud_sel_q;
  assign baud_rst_n = baud_rst_n_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// Testbench for uart_tx_scheduler: scenario tasks against a transaction-level
// model (round-robin pointer, current generator rate, configured flag).
module tb_uart_tx_scheduler;

  localparam int NREQ   = 4;
  localparam int SETTLE = 4;
  localparam int TOUT   = 50;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_rate;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [1:0]        baud_sel;
  logic              baud_rst_n;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         model_rr;
  bit         model_cfg_valid;
  logic [1:0] model_sel;

  always #5 clock = ~clock;

  uart_tx_scheduler #(
    .NREQ(NREQ),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT(TOUT),
    .TO_W(20)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req(req),
    .req_data(req_data),
    .req_rate(req_rate),
    .grant(grant),
    .ack(ack),
    .err(err),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .baud_sel(baud_sel),
    .baud_rst_n(baud_rst_n)
  );

  task automatic set_req(input int j, input logic [7:0] d, input logic [1:0] r);
    req_data[8*j +: 8] = d;
    req_rate[2*j +: 2] = r;
    req[j] = 1'b1;
  endtask

  // Runs one transaction. Called at a negedge in IDLE with req already set.
  // dly: WAIT cycle index on which tx_done is pulsed; outside 0..TOUT-1 means
  // no tx_done (timeout). rearm: request bits raised after the grant.
  task automatic do_txn(input int dly, input logic [NREQ-1:0] rearm,
                        input bit add_random, output int won);
    int w, n, lowcnt, exp_n, j;
    bit settle, seen, exp_err, got_ack;
    logic [7:0] ed;
    logic [1:0] er;
    logic [NREQ-1:0] exp_g;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && req[(model_rr + k) % NREQ]) w = (model_rr + k) % NREQ;
    won = w;
    if (w < 0) begin
      checks++; errors++;
      $display("FAIL txn_setup: no request pending (req=%b)", req);
      return;
    end
    ed = req_data[8*w +: 8];
    er = req_rate[2*w +: 2];
    exp_g = '0; exp_g[w] = 1'b1;
    settle = !model_cfg_valid || (er != model_sel);
    exp_err = !(dly >= 0 && dly < TOUT);
    exp_n = exp_err ? TOUT + 1 : dly + 2;

    // CFG cycle
    @(negedge clock);
    checks++; if (grant !== exp_g) begin errors++; $display("FAIL grant: got %b want %b", grant, exp_g); end
    checks++; if (tx_data !== ed) begin errors++; $display("FAIL tx_data: got %h want %h", tx_data, ed); end
    checks++; if (baud_sel !== model_sel) begin errors++; $display("FAIL baud_sel_pre_cfg: got %b want %b", baud_sel, model_sel); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_early: got %b want 0", tx_start); end
    req = req | rearm;

    // SETTLE/START: spurious tx_done here must be ignored
    n = 0; lowcnt = 0; seen = 0;
    while (!seen && n < SETTLE + 5) begin
      tx_done = ($urandom_range(0, 3) == 0);
      @(negedge clock); n++;
      if (baud_rst_n === 1'b0) lowcnt++;
      if (tx_start === 1'b1) seen = 1;
      checks++;
      if (grant !== exp_g || tx_data !== ed) begin
        errors++; $display("FAIL hold_setup: grant %b data %h want %b %h", grant, tx_data, exp_g, ed);
      end
    end
    tx_done = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL tx_start_missing: got none want 1 pulse"); end
    checks++; if (n !== (settle ? SETTLE + 1 : 1)) begin errors++; $display("FAIL start_latency: got %0d want %0d cycles after cfg", n, settle ? SETTLE + 1 : 1); end
    checks++; if (lowcnt !== (settle ? SETTLE : 0)) begin errors++; $display("FAIL settle_len: got %0d want %0d", lowcnt, settle ? SETTLE : 0); end
    checks++; if (baud_sel !== er) begin errors++; $display("FAIL baud_sel: got %b want %b", baud_sel, er); end
    checks++; if (baud_rst_n !== 1'b1) begin errors++; $display("FAIL baud_rst_n_start: got %b want 1", baud_rst_n); end
    if (settle) begin model_cfg_valid = 1; model_sel = er; end

    // WAIT
    n = 0; got_ack = 0;
    while (!got_ack && n < TOUT + 10) begin
      @(negedge clock); n++;
      tx_done = 1'b0;
      if (ack !== '0) got_ack = 1;
      else begin
        if (n == 1) begin
          checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_width: got %b want 0", tx_start); end
        end
        if (n - 1 == dly) tx_done = 1'b1;
        if (add_random && $urandom_range(0, 7) == 0) begin
          j = $urandom_range(0, NREQ - 1);
          if (!req[j]) set_req(j, 8'($urandom), 2'($urandom));
        end
      end
    end
    tx_done = 1'b0;
    checks++; if (n !== exp_n) begin errors++; $display("FAIL ack_latency: got %0d want %0d (ack seen %0d)", n, exp_n, got_ack); end
    checks++; if (ack !== exp_g) begin errors++; $display("FAIL ack: got %b want %b", ack, exp_g); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL err: got %b want %b", err, exp_err); end
    checks++; if (grant !== exp_g || tx_data !== ed) begin errors++; $display("FAIL hold_done: grant %b data %h want %b %h", grant, tx_data, exp_g, ed); end
    req[w] = 1'b0;

    // IDLE
    @(negedge clock);
    checks++;
    if (ack !== '0 || err !== 1'b0 || grant !== '0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL idle_after: ack %b err %b grant %b start %b want 0", ack, err, grant, tx_start);
    end
    model_rr = (w + 1) % NREQ;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; req = '0; req_data = '0; req_rate = '0; tx_done = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b want 0", grant); end
    checks++; if (ack !== '0 || err !== 1'b0) begin errors++; $display("FAIL rst_ack_err: got %b %b want 0 0", ack, err); end
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx: got %b %h want 0 00", tx_start, tx_data); end
    checks++; if (baud_sel !== 2'b00 || baud_rst_n !== 1'b0) begin errors++; $display("FAIL rst_baud: got %b %b want 00 0", baud_sel, baud_rst_n); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (baud_rst_n !== 1'b0 || grant !== '0) begin errors++; $display("FAIL idle_hold: baud_rst_n %b grant %b want 0 0", baud_rst_n, grant); end
    model_rr = 0; model_cfg_valid = 0; model_sel = 2'b00;
  endtask

  task automatic test_single;
    int won;
    set_req(0, 8'hA5, 2'b10);
    do_txn(20, '0, 0, won);
  endtask

  task automatic test_same_rate;
    int won;
    set_req(0, 8'h3C, 2'b10);
    do_txn($urandom_range(0, 30), '0, 0, won);
  endtask

  task automatic test_round_robin;
    int won, prev;
    int order [4] = '{0, 1, 3, 0};
    logic [NREQ-1:0] rearm;
    set_req(3, 8'($urandom), 2'($urandom));
    do_txn($urandom_range(0, 20), '0, 0, won); // pointer wraps to 0
    set_req(0, 8'($urandom), 2'($urandom));
    set_req(1, 8'($urandom), 2'($urandom));
    set_req(3, 8'($urandom), 2'($urandom));
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      rearm = '0;
      if (prev >= 0) rearm[prev] = 1'b1;
      do_txn($urandom_range(0, 20), rearm, 0, won);
      checks++; if (won !== order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, won, order[i]); end
      prev = won;
    end
    req = '0;
  endtask

  task automatic test_rate_change;
    int won;
    set_req(1, 8'h11, 2'b00);
    do_txn($urandom_range(0, 20), '0, 0, won);
    checks++; if (baud_sel !== 2'b00) begin errors++; $display("FAIL rate_first: got %b want 00", baud_sel); end
    set_req(1, 8'h22, 2'b11);
    do_txn($urandom_range(0, 20), '0, 0, won);
    checks++; if (baud_sel !== 2'b11) begin errors++; $display("FAIL rate_second: got %b want 11", baud_sel); end
  endtask

  task automatic test_timeout;
    int won;
    set_req(2, 8'h5A, 2'($urandom));
    do_txn(-1, '0, 0, won);
    set_req(3, 8'h6B, 2'($urandom));
    do_txn($urandom_range(0, 30), '0, 0, won);
    set_req(0, 8'h7C, 2'($urandom));
    do_txn(TOUT - 1, '0, 0, won);
  endtask

  task automatic test_reset_mid_wait;
    int n, won;
    bit seen;
    set_req(2, 8'h99, 2'b01);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clock); n++;
      if (tx_start === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_start: got no tx_start want 1"); end
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if (grant !== '0 || ack !== '0 || err !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        baud_sel !== 2'b00 || baud_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_vals: g %b a %b e %b s %b d %h sel %b brn %b want all 0",
               grant, ack, err, tx_start, tx_data, baud_sel, baud_rst_n);
    end
    repeat (2) begin
      @(negedge clock);
      checks++; if (ack !== '0) begin errors++; $display("FAIL mid_no_ack: got %b want 0", ack); end
    end
    reset_n = 1'b1;
    model_rr = 0; model_cfg_valid = 0; model_sel = 2'b00;
    @(negedge clock);
    set_req(0, 8'hC3, 2'b00);
    set_req(3, 8'hD4, 2'b10);
    do_txn($urandom_range(0, 20), '0, 0, won);
    checks++; if (won !== 0) begin errors++; $display("FAIL post_reset_rr: got %0d want 0", won); end
    do_txn($urandom_range(0, 20), '0, 0, won);
  endtask

  task automatic test_random;
    int won, dly, r;
    for (int t = 0; t < 40; t++) begin
      if (req == '0 || $urandom_range(0, 2) == 0)
        for (int j = 0; j < NREQ; j++)
          if (!req[j] && $urandom_range(0, 1) == 1) set_req(j, 8'($urandom), 2'($urandom));
      if (req == '0) set_req($urandom_range(0, NREQ - 1), 8'($urandom), 2'($urandom));
      r = $urandom_range(0, 15);
      if (r == 0) dly = -1;
      else if (r == 1) dly = TOUT - 1;
      else dly = $urandom_range(0, 30);
      do_txn(dly, '0, 1, won);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_rate();
    test_round_robin();
    test_rate_change();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
